// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // pc_write is unconditional (gated by memReady in FETCH); pc_write_cond is gated by zero.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       write_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word decode (Moore part of the control unit).
// JUMP decode exists only with MULTICYCLE_CONTROL_JUMP_EN.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
      end
      DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH;
      MEMADR, ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      MEMWB: begin
        ctrl_o.write_reg  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_o.write_reg = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ADDIWB: ctrl_o.write_reg = 1'b1;
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      JUMP: begin
        ctrl_o.pc_src   = PCSRC_JUMP;
        ctrl_o.pc_write = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and memReady/zero gating.
// Optional JUMP support is enabled by defining MULTICYCLE_CONTROL_JUMP_EN.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned AOPW = 2,
  parameter int unsigned STW  = 4
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic [OPW-1:0]  opCode,
  input  logic            memReady,
  input  logic            zero,
  output logic            iorD,
  output logic            memRead,
  output logic            memWrite,
  output logic            irWrite,
  output logic            pcWrite,
  output logic            regDst,
  output logic            memToReg,
  output logic            writeReg,
  output logic            aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic [AOPW-1:0] aluOp,
  output logic [1:0]      pcSrc,
  output logic            illegalOp,
  output logic [STW-1:0]  state
);

  state_t state_q, state_d;
  logic   illegal;
  ctrl_t  ctrl, ctrl_g;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      FETCH:  if (memReady) state_d = DECODE;
      DECODE: begin
        case (opCode)
          OPW'(OP_RTYPE):        state_d = EXEC;
          OPW'(OP_LW), OPW'(OP_SW): state_d = MEMADR;
          OPW'(OP_BEQ):          state_d = BRANCH;
          OPW'(OP_ADDI):         state_d = ADDIEX;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
          OPW'(OP_J):            state_d = JUMP;
`endif
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (opCode == OPW'(OP_LW))      state_d = MEMRD;
        else if (opCode == OPW'(OP_SW)) state_d = MEMWR;
        else                            state_d = FETCH;
      end
      MEMRD:  if (memReady) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (memReady) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      BRANCH: state_d = FETCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
      JUMP:   state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // State already reads FETCH during reset, so every output is forced low while rstN=0.
  assign ctrl_g = rstN ? ctrl : '0;

  assign iorD      = ctrl_g.iord;
  assign memRead   = ctrl_g.mem_read;
  assign memWrite  = ctrl_g.mem_write;
  assign irWrite   = ctrl_g.ir_write & memReady;
  assign pcWrite   = (ctrl_g.pc_write & ((state_q != FETCH) | memReady))
                   | (ctrl_g.pc_write_cond & zero);
  assign regDst    = ctrl_g.reg_dst;
  assign memToReg  = ctrl_g.mem_to_reg;
  assign writeReg  = ctrl_g.write_reg;
  assign aluSrcA   = ctrl_g.alu_src_a;
  assign aluSrcB   = ctrl_g.alu_src_b;
  assign aluOp     = AOPW'(ctrl_g.alu_op);
  assign pcSrc     = ctrl_g.pc_src;
  assign illegalOp = illegal & rstN;
  assign state     = STW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: random instruction streams versus a per-instruction cycle-trace model.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk, rstN, memReady, zero;
  logic [5:0] opCode;
  logic       iorD, memRead, memWrite, irWrite, pcWrite, regDst, memToReg, writeReg;
  logic       aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    state_t     st;
    logic       mr;
    logic       z;
    logic       ill;
    logic [5:0] op;
  } cyc_t;

  cyc_t q[$];

  multicycle_control dut (
    .clk       (clk),
    .rstN      (rstN),
    .opCode    (opCode),
    .memReady  (memReady),
    .zero      (zero),
    .iorD      (iorD),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .irWrite   (irWrite),
    .pcWrite   (pcWrite),
    .regDst    (regDst),
    .memToReg  (memToReg),
    .writeReg  (writeReg),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .pcSrc     (pcSrc),
    .illegalOp (illegalOp),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_word();
    return {iorD, memRead, memWrite, irWrite, pcWrite, regDst, memToReg, writeReg,
            aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp};
  endfunction

  // Expected control word straight from the per-state behaviour table.
  function automatic logic [15:0] exp_word(state_t s, logic mr, logic z, logic ill);
    logic iord, rd, wr, ir, pw, rdst, m2r, wreg, sa;
    logic [1:0] sb, ao, ps;
    {iord, rd, wr, ir, pw, rdst, m2r, wreg, sa} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      FETCH:  begin rd = 1; ir = mr; pw = mr; sb = 2'b01; end
      DECODE: sb = 2'b11;
      MEMADR: begin sa = 1; sb = 2'b10; end
      MEMRD:  begin rd = 1; iord = 1; end
      MEMWB:  begin wreg = 1; m2r = 1; end
      MEMWR:  begin wr = 1; iord = 1; end
      EXEC:   begin sa = 1; ao = 2'b10; end
      ALUWB:  begin wreg = 1; rdst = 1; end
      ADDIEX: begin sa = 1; sb = 2'b10; end
      ADDIWB: wreg = 1;
      BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; pw = z; end
      JUMP:   begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {iord, rd, wr, ir, pw, rdst, m2r, wreg, sa, sb, ao, ps, ill};
  endfunction

  function automatic logic jump_en();
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI ||
           (op == OP_J && jump_en());
  endfunction

  task automatic push(state_t st, logic mr, logic z, logic ill, logic [5:0] op);
    cyc_t c;
    c.st = st; c.mr = mr; c.z = z; c.ill = ill; c.op = op;
    q.push_back(c);
  endtask

  // Expands one instruction into its expected per-cycle trace. opCode is junk outside
  // DECODE/MEMADR to show it is ignored there.
  task automatic build_instr(logic [5:0] op, int fw, int mw, logic bz);
    logic [5:0] junk;
    for (int i = 0; i < fw; i++) begin
      junk = 6'($urandom);
      push(FETCH, 1'b0, 1'($urandom), 1'b0, junk);
    end
    push(FETCH, 1'b1, 1'($urandom), 1'b0, 6'($urandom));
    push(DECODE, 1'($urandom), 1'($urandom), !is_legal(op), op);
    if (!is_legal(op)) return;
    if (op == OP_RTYPE) begin
      push(EXEC, 1'($urandom), 1'($urandom), 1'b0, 6'($urandom));
      push(ALUWB, 1'($urandom), 1'($urandom), 1'b0, 6'($urandom));
    end else if (op == OP_LW || op == OP_SW) begin
      push(MEMADR, 1'($urandom), 1'($urandom), 1'b0, op);
      for (int i = 0; i < mw; i++)
        push((op == OP_LW) ? MEMRD : MEMWR, 1'b0, 1'($urandom), 1'b0, 6'($urandom));
      push((op == OP_LW) ? MEMRD : MEMWR, 1'b1, 1'($urandom), 1'b0, 6'($urandom));
      if (op == OP_LW) push(MEMWB, 1'($urandom), 1'($urandom), 1'b0, 6'($urandom));
    end else if (op == OP_BEQ) begin
      push(BRANCH, 1'($urandom), bz, 1'b0, 6'($urandom));
    end else if (op == OP_ADDI) begin
      push(ADDIEX, 1'($urandom), 1'($urandom), 1'b0, 6'($urandom));
      push(ADDIWB, 1'($urandom), 1'($urandom), 1'b0, 6'($urandom));
    end else begin
      push(JUMP, 1'($urandom), 1'($urandom), 1'b0, 6'($urandom));
    end
  endtask

  // Entered just after a posedge with the DUT sitting in the first queued state.
  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      opCode = c.op; memReady = c.mr; zero = c.z;
      @(negedge clk);
      check_eq("state", 32'(state), 32'(c.st));
      check_eq($sformatf("ctrl@%s", c.st.name()), 32'(dut_word()),
               32'(exp_word(c.st, c.mr, c.z, c.ill)));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] v;
    case ($urandom_range(0, 6))
      0: return OP_RTYPE;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_ADDI;
      5: return OP_J;
      default: begin
        v = 6'($urandom);
        while (is_legal(v)) v = 6'($urandom);
        return v;
      end
    endcase
  endfunction

  initial begin
    rstN = 1'b0; memReady = 1'b1; zero = 1'b0; opCode = OP_LW;
    #12;
    check_eq("reset_state", 32'(state), 32'(FETCH));
    check_eq("reset_ctrl", 32'(dut_word()), 32'h0);
    memReady = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Directed: lw, fetch waits, beq taken/not, illegal, j, sw with memory waits.
    build_instr(OP_LW, 0, 0, 1'b0);
    build_instr(OP_RTYPE, 3, 0, 1'b0);
    build_instr(OP_BEQ, 0, 0, 1'b1);
    build_instr(OP_BEQ, 0, 0, 1'b0);
    build_instr(6'b111111, 0, 0, 1'b0);
    build_instr(OP_J, 0, 0, 1'b0);
    build_instr(OP_SW, 0, 2, 1'b0);
    build_instr(OP_ADDI, 1, 0, 1'b0);
    run_queue();

    for (int n = 0; n < 60; n++)
      build_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    run_queue();

    // Reset in the middle of a lw MEMRD.
    opCode = OP_LW; memReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    memReady = 1'b0;
    #2;
    check_eq("pre_abort_state", 32'(state), 32'(MEMRD));
    rstN = 1'b0;
    memReady = 1'b1;
    #1;
    check_eq("abort_state", 32'(state), 32'(FETCH));
    check_eq("abort_ctrl", 32'(dut_word()), 32'h0);
    @(negedge clk);
    check_eq("held_ctrl", 32'(dut_word()), 32'h0);
    memReady = 1'b0;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_state", 32'(state), 32'(FETCH));
    check_eq("post_rst_ctrl", 32'(dut_word()), 32'(exp_word(FETCH, 1'b0, 1'b0, 1'b0)));
    memReady = 1'b1;
    #2;
    check_eq("post_rst_fetch", 32'(dut_word()), 32'(exp_word(FETCH, 1'b1, 1'b0, 1'b0)));
    @(posedge clk);
    #1;
    check_eq("post_rst_decode", 32'(state), 32'(DECODE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
